// File: rtl/alu.sv
// alu: registered 32-bit integer ALU for the execute stage; one operation per clock, 1-cycle latency
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Opin,
    output logic [WIDTH-1:0] result
);
    localparam int SW = $clog2(WIDTH);

    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] nxt;

    assign shamt = B[SW-1:0];

    // opcode decode; reserved and unknown opcodes fall through to zero so nothing latches
    always_comb begin
        nxt = '0;
        case (Opin)
            4'b0000: nxt = A + B;
            4'b0001: nxt = A - B;
            4'b0010: nxt = A & B;
            4'b0011: nxt = A | B;
            4'b0100: nxt = A ^ B;
            4'b0101: nxt = ~(A | B);
            4'b0110: nxt = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            4'b0111: nxt = {{(WIDTH-1){1'b0}}, A < B};
            4'b1000: nxt = A << shamt;
            4'b1001: nxt = A >> shamt;
            4'b1010: nxt = $unsigned($signed(A) >>> shamt);
            4'b1011: nxt = A;
            4'b1100: nxt = B;
            4'b1101: nxt = ~A;
            default: nxt = '0;
        endcase
    end

    // output register; reset wins over any operation
    always_ff @(posedge clk) begin
        if (reset) result <= '0;
        else       result <= nxt;
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu: randomized and directed check of alu against an arithmetic reference model
module tb_alu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [3:0]  Opin = '0;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q = '0;
    logic        exp_valid = 1'b0;

    alu #(.WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .A(A),
        .B(B),
        .Opin(Opin),
        .result(result)
    );

    always #5 clk = ~clk;

    localparam longint M = 64'sh1_0000_0000;

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint p  = longint'(1) << (b % 32);
        longint r;
        case (op)
            4'd0:    r = (ua + ub) % M;
            4'd1:    r = (ua - ub + M) % M;
            4'd2:    r = longint'(a & b);
            4'd3:    r = longint'(a | b);
            4'd4:    r = longint'(a ^ b);
            4'd5:    r = longint'(~(a | b));
            4'd6:    r = (sa < sb) ? 1 : 0;
            4'd7:    r = (ua < ub) ? 1 : 0;
            4'd8:    r = (ua * p) % M;
            4'd9:    r = ua / p;
            4'd10:   r = (sa < 0) ? -((-sa - 1) / p) - 1 : sa / p;
            4'd11:   r = ua;
            4'd12:   r = ub;
            4'd13:   r = longint'(~a);
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: result=%h expected=%h", name, got, want);
        end
    endtask

    // expected value captured from the inputs the DUT samples at this edge
    always @(posedge clk) begin
        exp_q     <= reset ? 32'h0 : model(A, B, Opin);
        exp_valid <= 1'b1;
    end

    // compare DUT against model every cycle, away from the active edge
    always @(negedge clk) begin
        if (exp_valid) check("model", result, exp_q);
    end

    task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        @(negedge clk);
        reset = r;
        A     = a;
        B     = b;
        Opin  = op;
        @(posedge clk);
        #1;
    endtask

    task automatic dir(input string name, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input logic [31:0] want);
        step(1'b0, a, b, op);
        check(name, result, want);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 63));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        step(1'b1, $urandom, $urandom, 4'd0);
        check("reset0", result, 32'h0);
        step(1'b1, $urandom, $urandom, 4'd13);
        check("reset1", result, 32'h0);

        dir("xor",  32'h1B, 32'h2E, 4'b0100, 32'h0000_0035);
        dir("add",  32'h1B, 32'h2E, 4'b0000, 32'h0000_0049);
        dir("sub",  32'h1B, 32'h2E, 4'b0001, 32'hFFFF_FFED);
        dir("and",  32'h1B, 32'h2E, 4'b0010, 32'h0000_000A);
        dir("or",   32'h1B, 32'h2E, 4'b0011, 32'h0000_003F);
        dir("nor",  32'h1B, 32'h2E, 4'b0101, 32'hFFFF_FFC0);
        dir("slt_neg",  32'hFFFF_FFFF, 32'h1, 4'b0110, 32'h1);
        dir("sltu_neg", 32'hFFFF_FFFF, 32'h1, 4'b0111, 32'h0);
        dir("slt_pos",  32'h1B, 32'h2E, 4'b0110, 32'h1);
        dir("sra",  32'h8000_0000, 32'h21, 4'b1010, 32'hC000_0000);
        dir("srl",  32'h8000_0000, 32'h21, 4'b1001, 32'h4000_0000);
        dir("sll",  32'h8000_0000, 32'h21, 4'b1000, 32'h0);
        dir("wrap", 32'hFFFF_FFFF, 32'h1, 4'b0000, 32'h0);
        dir("sh0",  32'hDEAD_BEEF, 32'h20, 4'b1001, 32'hDEAD_BEEF);
        dir("passa", 32'h1234_5678, 32'h9ABC_DEF0, 4'b1011, 32'h1234_5678);
        dir("passb", 32'h1234_5678, 32'h9ABC_DEF0, 4'b1100, 32'h9ABC_DEF0);
        dir("nota",  32'h1234_5678, 32'h0, 4'b1101, 32'hEDCB_A987);
        dir("rsv15", 32'h1234_5678, 32'h1, 4'b1111, 32'h0);

        dir("pre_rst_add", 32'h100, 32'h23, 4'b0000, 32'h123);
        step(1'b1, 32'h100, 32'h23, 4'b0000);
        check("mid_reset", result, 32'h0);
        dir("rsv14", 32'h100, 32'h23, 4'b1110, 32'h0);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 49) == 0, rnd_operand(), rnd_operand(), 4'($urandom_range(0, 15)));

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
